// File: rtl/acia_rx_fifo.sv
// Receive buffer behind the serial receiver: first-word-fall-through byte FIFO
// with sticky overflow, framing-error and line-idle flags plus a level interrupt.
module acia_rx_fifo #(
   parameter int DLOG2    = 4,
   parameter int THRESH   = 8,
   parameter int ICW      = 12,
   parameter int IDLE_CYC = 1390
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_dat,
   input  logic             rx_stb,
   input  logic             rx_err,
   input  logic             rd_pop,
   input  logic             clr_flags,
   output logic [7:0]       rd_dat,
   output logic             rd_valid,
   output logic [DLOG2:0]   count,
   output logic             ovf,
   output logic             ferr,
   output logic             idle,
   output logic             irq
);
   localparam int DEPTH = 1 << DLOG2;
   localparam int CW    = DLOG2 + 1;
   localparam logic [CW-1:0]  FULL   = CW'(DEPTH);
   localparam logic [CW-1:0]  TH     = CW'(THRESH);
   localparam logic [ICW-1:0] T_LAST = ICW'(IDLE_CYC - 1);
   localparam logic [ICW-1:0] T_FIRE = ICW'(IDLE_CYC - 2);

   logic [7:0]       mem [DEPTH];
   logic [DLOG2-1:0] wptr, rptr;
   logic [ICW-1:0]   tmr;
   logic             rx_err_d;
   logic             pop_ok, push_ok, ovf_set, ferr_set, idle_fire;

   assign pop_ok    = rd_pop && (count != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok   = rx_stb && ((count != FULL) || pop_ok);
   assign ovf_set   = rx_stb && !push_ok;
   assign ferr_set  = rx_err && !rx_err_d;
   // Fires on the edge where the timer steps onto its last value.
   assign idle_fire = (count != '0) && !push_ok && (tmr == T_FIRE);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= rx_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         tmr      <= '0;
         rx_err_d <= 1'b0;
         ovf      <= 1'b0;
         ferr     <= 1'b0;
         idle     <= 1'b0;
      end else begin
         rx_err_d <= rx_err;
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;

         if (push_ok || (count == '0)) tmr <= '0;
         else if (tmr != T_LAST)       tmr <= tmr + 1'b1;

         // Set events win over a same-cycle clear.
         ovf  <= ovf_set   || (ovf  && !clr_flags);
         ferr <= ferr_set  || (ferr && !clr_flags);
         idle <= idle_fire || (idle && !(pop_ok || clr_flags));
      end
   end

   assign rd_dat   = mem[rptr];
   assign rd_valid = (count != '0);
   assign irq      = ovf || ferr || idle || (count >= TH);

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed bench for acia_rx_fifo: pushed bytes go into a scoreboard queue and a
// monitor compares rd_dat on every accepted pop; status is checked inline.
module tb_acia_rx_fifo;
   logic       clk = 1'b0;
   logic       rst, rx_stb, rx_err, rd_pop, clr_flags;
   logic [7:0] rx_dat, rd_dat;
   logic       rd_valid, ovf, ferr, idle, irq;
   logic [4:0] count;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];

   acia_rx_fifo dut (
      .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_stb(rx_stb), .rx_err(rx_err),
      .rd_pop(rd_pop), .clr_flags(clr_flags), .rd_dat(rd_dat), .rd_valid(rd_valid),
      .count(count), .ovf(ovf), .ferr(ferr), .idle(idle), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst && rd_pop && rd_valid) begin
         if (exp_q.size() == 0) chk("pop_unexpected", {24'h0, rd_dat}, 32'hdead);
         else chk("pop_data", {24'h0, rd_dat}, {24'h0, exp_q.pop_front()});
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b, input bit stored = 1'b1);
      rx_dat = b;
      rx_stb = 1'b1;
      if (stored) exp_q.push_back(b);
      tick();
      rx_stb = 1'b0;
   endtask

   task automatic pop();
      rd_pop = 1'b1;
      tick();
      rd_pop = 1'b0;
   endtask

   task automatic clr();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; rx_stb = 1'b0; rx_err = 1'b0; rd_pop = 1'b0; clr_flags = 1'b0; rx_dat = 8'h00;
      tick(3);
      rst = 1'b0;
      tick();
      chk("rst_count", count, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_irq", irq, 0);
      chk("rst_flags", {ovf, ferr, idle}, 0);

      // Ordered round trip with spaced strobes
      push(8'h55); tick(2);
      push(8'hA3); tick(2);
      push(8'h0F);
      chk("three_count", count, 3);
      chk("three_head", rd_dat, 8'h55);
      for (int i = 2; i >= 0; i--) begin
         pop();
         chk("drain_count", count, i);
      end
      chk("drain_valid", rd_valid, 0);

      // Fill to depth, irq from 8th push on, then overflow
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         chk("fill_irq", irq, (i >= 7) ? 1 : 0);
      end
      chk("full_count", count, 16);
      chk("full_ovf_pre", ovf, 0);
      push(8'hEE, 1'b0);
      chk("ovf_set", ovf, 1);
      chk("ovf_count", count, 16);
      clr();
      chk("ovf_clr", ovf, 0);

      // Push and pop together while full: no overflow
      rx_dat = 8'h77; rx_stb = 1'b1; rd_pop = 1'b1;
      exp_q.push_back(8'h77);
      tick();
      rx_stb = 1'b0; rd_pop = 1'b0;
      chk("simul_count", count, 16);
      chk("simul_ovf", ovf, 0);
      repeat (15) pop();
      chk("simul_head", rd_dat, 8'h77);
      chk("simul_count1", count, 1);
      pop();
      chk("empty_after", rd_valid, 0);
      pop();
      chk("pop_empty_count", count, 0);

      // Framing error edge and clear while held high
      rx_err = 1'b1;
      tick();
      chk("ferr_set", ferr, 1);
      tick(1999);
      chk("ferr_hold", ferr, 1);
      clr();
      chk("ferr_clr", ferr, 0);
      tick(20);
      chk("ferr_no_reset", ferr, 0);
      rx_err = 1'b0;
      tick();
      chk("ferr_low", ferr, 0);
      rx_err = 1'b1; clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("ferr_set_wins", ferr, 1);
      rx_err = 1'b0;
      clr();
      chk("ferr_final_clr", ferr, 0);

      // Idle timeout after the last push
      push(8'hAB);
      tick(1388);
      chk("idle_early", idle, 0);
      chk("idle_early_irq", irq, 0);
      tick();
      chk("idle_set", idle, 1);
      chk("idle_irq", irq, 1);
      pop();
      chk("idle_pop_clr", idle, 0);
      push(8'hCD);
      tick(500);
      pop();
      tick(1500);
      chk("idle_empty_first", idle, 0);

      // Reset with 5 bytes stored and ovf set
      for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
      push(8'hFF, 1'b0);
      repeat (11) pop();
      chk("pre_rst_count", count, 5);
      chk("pre_rst_ovf", ovf, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      chk("mid_rst_count", count, 0);
      chk("mid_rst_valid", rd_valid, 0);
      chk("mid_rst_flags", {ovf, ferr, idle, irq}, 0);
      push(8'h3C);
      chk("post_rst_head", rd_dat, 8'h3C);
      pop();
      chk("post_rst_count", count, 0);
      chk("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/acia_rx_fifo.md
# acia_rx_fifo

Receive buffer stage that sits directly downstream of the asynchronous serial receiver. It captures each received byte strobe into a 16-entry first-word-fall-through FIFO and presents the head byte and status to the CPU bus interface. It also tracks sticky overflow and framing-error flags, detects receive-line idle while data is pending, and produces a level interrupt.

## Interface
- DLOG2, default 4: log2 of FIFO depth; depth = 2^DLOG2 = 16.
- THRESH, default 8: fill level at or above which the interrupt asserts.
- ICW, default 12: idle timer width in bits.
- IDLE_CYC, default 1390: idle timeout in clk cycles; 10 bit times at 139 clk per bit.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_dat  in  8  received byte from the receiver; valid only while rx_stb is high.
- rx_stb  in  1  one-cycle pulse: rx_dat holds a good frame.
- rx_err  in  1  receiver framing-error level; held until the next good frame.
- rd_pop  in  1  CPU pop request, one cycle; discards the head byte.
- clr_flags  in  1  one-cycle pulse: clears ovf, ferr and idle.
- rd_dat  out  8  head byte of the FIFO; valid when rd_valid is high.
- rd_valid  out  1  FIFO not empty.
- count  out  DLOG2+1  number of bytes stored, 0..16.
- ovf  out  1  sticky flag: a byte was dropped because the FIFO was full.
- ferr  out  1  sticky flag: a framing error was seen.
- idle  out  1  sticky flag: the line went idle while data was pending.
- irq  out  1  ovf | ferr | idle | (count >= THRESH).

## Operation
- Storage is 2^DLOG2 x 8 memory with DLOG2-bit write and read pointers that wrap modulo depth, plus a separate count register.
- **Push:** taken when rx_stb=1 and (count<depth, or rd_pop is accepted in the same cycle).
  - Writes rx_dat at wptr, increments wptr.
- **Push while full, no pop:** the byte is dropped. wptr and count are unchanged and ovf is set.
- **Pop:** accepted when rd_pop=1 and count>0; increments rptr. rd_pop while empty is ignored with no error.
- **Simultaneous push and pop:** both take effect and count is unchanged. This includes the full case, where no overflow occurs.
- Count update: count += push_ok − pop_ok.
- **rd_dat:** rd_dat = mem[rptr], read combinationally from the pointer register. When empty its value is don't-care.
- **ferr:** set on a rising edge of rx_err, detected with a one-cycle delayed copy of rx_err.
  - Consecutive bad frames with no good frame between them produce a single edge. This is an accepted limitation.
- **Idle timer:** an ICW-bit counter, cleared on any push and whenever count=0.
  - It increments each cycle while count>0 and no push occurs.
  - When it reaches IDLE_CYC−1, idle is set and the counter holds. The timer does not re-fire until the next push clears it.
- **idle** clears on any accepted pop or on clr_flags. Set has priority over clear in the same cycle.
- **ovf and ferr** clear only on clr_flags. A set event in the same cycle as clr_flags wins, and the flag stays 1.
- **Reset:** wptr, rptr, count, timer, ovf, ferr, idle and the delayed rx_err copy all go to 0.
  - Outputs after reset: rd_valid=0, count=0, irq=0, rd_dat don't-care.
  - Memory contents are not reset.
  - Reset mid-stream discards all stored bytes.

## Timing
- Push latency: rx_stb high in cycle N gives count+1, rd_valid=1 and the byte on rd_dat (if the FIFO was empty) in cycle N+1.
- Pop latency: rd_pop in cycle N advances rd_dat to the next byte and decrements count in cycle N+1.
- ferr: rx_err rising in cycle N sets ferr visible in cycle N+1.
- Idle: with the last push in cycle N, idle is visible at cycle N+IDLE_CYC, i.e. the timer reaches IDLE_CYC−1 and the flag registers on the next edge.
- irq is combinational from registered state and carries no extra latency.
- Back-to-back rx_stb pulses on consecutive cycles must all be accepted. The receiver never produces them, but the buffer must not rely on that.

## Test plan
- Push 0x55, 0xA3, 0x0F with spaced rx_stb, then pop 3 times.
  - rd_dat must read 0x55, 0xA3, 0x0F in order.
  - count must go 3→0 and rd_valid must drop after the third pop.
- Push 16 bytes 0x00..0x0F, then push 0xEE.
  - count=16, irq=1 from the 8th push onward, and ovf=1 after 0xEE.
  - Popping all 16 returns 0x00..0x0F with no 0xEE.
- With the FIFO full, assert rx_stb(0x77) and rd_pop in the same cycle.
  - count stays 16 and ovf stays 0.
  - After 15 further pops, rd_dat=0x77.
- Raise rx_err for 2000 cycles, then pulse clr_flags while rx_err is still high.
  - ferr=1 one cycle after the rise, and ferr=0 after the clear.
  - No re-set occurs until rx_err falls and rises again.
- Push one byte, then wait.
  - idle=1 exactly 1390 cycles after the push and irq=1.
  - A pop clears idle. A timer sequence where the FIFO empties first must not set idle.
- Assert rst with 5 bytes stored and ovf=1.
  - Next cycle: count=0, rd_valid=0, ovf=ferr=idle=irq=0.
  - A following push/pop round-trips correctly.
